// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision helpers for the floating-point front-ends.
package fp_pkg;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } fp_pair_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_OUT
  } div_state_e;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] != 23'h0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] == 23'h0);
  endfunction

  // Denormals flush to zero, so only the exponent matters.
  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00);
  endfunction

endpackage

// File: rtl/fp_div_special.sv
// Bypass resolver for division operands the core must not see (NaN, Inf, zero).
module fp_div_special
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_special,
  output logic [31:0] result,
  output logic        exception
);

  logic w_sign;

  assign w_sign = a[31] ^ b[31];

  // First matching rule wins.
  always_comb begin
    is_special = 1'b1;
    result     = QNAN;
    exception  = 1'b1;
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b)) ||
        (is_zero(a) && is_zero(b))) begin
      result    = QNAN;
      exception = 1'b1;
    end else if (is_zero(b)) begin
      result    = {w_sign, EXP_MAX, 23'h0};
      exception = 1'b1;
    end else if (is_inf(a)) begin
      result    = {w_sign, EXP_MAX, 23'h0};
      exception = 1'b0;
    end else if (is_inf(b) || is_zero(a)) begin
      result    = {w_sign, 31'h0};
      exception = 1'b0;
    end else begin
      is_special = 1'b0;
      result     = 32'h0;
      exception  = 1'b0;
    end
  end

endmodule

// File: rtl/fp_div_issue.sv
// Operand FIFO plus issue/settle/return sequencer around a combinational FP divider core.
module fp_div_issue
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_result,
  input  logic        div_exception,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_exception,
  output logic        out_special,
  output logic        busy
);

  localparam int unsigned PTR_W       = $clog2(DEPTH);
  localparam int unsigned CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PTR_W:0]   FULL_CNT    = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

  fp_pair_t          r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  div_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_div_a;
  logic [31:0]       r_div_b;
  logic [31:0]       r_out_result;
  logic              r_out_exception;
  logic              r_out_special;
  logic              r_out_valid;

  fp_pair_t          w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_sp_special;
  logic [31:0]       w_sp_result;
  logic              w_sp_exception;

  assign w_head   = r_mem[r_rd_ptr];
  assign in_ready = (r_count != FULL_CNT);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_state == ST_IDLE) && (r_count != '0);
  assign busy     = (r_state != ST_IDLE) || (r_count != '0);

  assign div_a         = r_div_a;
  assign div_b         = r_div_b;
  assign out_valid     = r_out_valid;
  assign out_result    = r_out_result;
  assign out_exception = r_out_exception;
  assign out_special   = r_out_special;

  fp_div_special u_special (
    .a          (w_head.a),
    .b          (w_head.b),
    .is_special (w_sp_special),
    .result     (w_sp_result),
    .exception  (w_sp_exception)
  );

  // Storage needs no reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_div_a         <= '0;
      r_div_b         <= '0;
      r_out_result    <= '0;
      r_out_exception <= 1'b0;
      r_out_special   <= 1'b0;
      r_out_valid     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_div_a <= w_head.a;
            r_div_b <= w_head.b;
            if (w_sp_special) begin
              r_out_result    <= w_sp_result;
              r_out_exception <= w_sp_exception;
              r_out_special   <= 1'b1;
              r_out_valid     <= 1'b1;
              r_state         <= ST_OUT;
            end else begin
              r_cnt   <= SETTLE_LOAD;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_out_result    <= div_result;
            r_out_exception <= div_exception;
            r_out_special   <= 1'b0;
            r_out_valid     <= 1'b1;
            r_state         <= ST_OUT;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_issue.sv
// Directed scoreboard bench for fp_div_issue with a settle-aware divider core model.
module tb_fp_div_issue;

  localparam int SETTLE = 4;

  typedef struct packed {
    logic [31:0] r;
    logic        e;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_result;
  logic        div_exception;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_exception;
  logic        out_special;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t popped;

  fp_div_issue #(.DEPTH(4), .SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .div_a        (div_a),
    .div_b        (div_b),
    .div_result   (div_result),
    .div_exception(div_exception),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_exception(out_exception),
    .out_special  (out_special),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Core model: garbage until operands have been stable for SETTLE cycles.
  logic [31:0] pa = 32'h0;
  logic [31:0] pb = 32'h0;
  int          age = 0;
  logic        settled;
  always @(posedge clk) begin
    if (div_a !== pa || div_b !== pb) age <= 1;
    else if (age < 1000) age <= age + 1;
    pa <= div_a;
    pb <= div_b;
  end
  assign settled       = (div_a === pa) && (div_b === pb) && (age >= SETTLE - 1);
  assign div_result    = settled ? (div_a - div_b + 32'h3F800000) : 32'hDEADBEEF;
  assign div_exception = settled ? div_a[0] : 1'b1;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    logic s, an, bn, ai, bi, az, bz;
    s  = a[31] ^ b[31];
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    x.s = 1'b1;
    if (an || bn)             begin x.r = 32'h7FC00000;       x.e = 1'b1; end
    else if (ai && bi)        begin x.r = 32'h7FC00000;       x.e = 1'b1; end
    else if (az && bz)        begin x.r = 32'h7FC00000;       x.e = 1'b1; end
    else if (bz)              begin x.r = {s, 8'hFF, 23'h0};  x.e = 1'b1; end
    else if (ai)              begin x.r = {s, 8'hFF, 23'h0};  x.e = 1'b0; end
    else if (bi || az)        begin x.r = {s, 31'h0};         x.e = 1'b0; end
    else begin
      x.r = a - b + 32'h3F800000;
      x.e = a[0];
      x.s = 1'b0;
    end
    return x;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every handshaken result against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out observed=%h expected=none", out_result);
      end
      if (sb.size() != 0) begin
        popped = sb.pop_front();
        check32("out_result", out_result, popped.r);
        check32("out_exception", 32'(out_exception), 32'(popped.e));
        check32("out_special", 32'(out_special), 32'(popped.s));
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, output int waits);
    logic acc;
    acc   = 1'b0;
    waits = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else waits++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (acc) sb.push_back(model(a, b));
    check_int("push_accepted", 32'(acc), 1);
  endtask

  task automatic latency(input string tag, input int exp);
    int k;
    k = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin k = n; break; end
    end
    check_int(tag, k, exp);
  endtask

  task automatic drain(input string tag);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      if (sb.size() == 0 && !busy && !out_valid) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_int(tag, 32'(done), 1);
  endtask

  logic [31:0] s_res, s_a, s_b;
  logic        s_exc;
  logic        stable, nopop, stale;
  int          w, wsum;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_out_valid", 32'(out_valid), 0);
    check32("rst_in_ready", 32'(in_ready), 1);
    check32("rst_busy", 32'(busy), 0);
    check32("rst_div_a", div_a, 32'h0);
    check32("rst_out_result", out_result, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Normal path: 6.0 / 2.0
    push(32'h40C00000, 32'h40000000, w);
    latency("lat_normal", 1 + SETTLE);
    drain("drain_t1");

    // Divide by zero, both signs, special path latency
    push(32'h3F800000, 32'h00000000, w);
    latency("lat_special_pos", 1);
    drain("drain_t2a");
    push(32'hBF800000, 32'h00000000, w);
    latency("lat_special_neg", 1);
    drain("drain_t2b");

    // Special priority table plus zero/denormal results
    push(32'h00000000, 32'h00000000, w);
    push(32'h7F800000, 32'h7F800000, w);
    push(32'h7FC00001, 32'h40000000, w);
    push(32'h7F800000, 32'h40000000, w);
    drain("drain_t3a");
    push(32'hC0000000, 32'h7F800000, w);
    push(32'h80000000, 32'h40000000, w);
    push(32'h00000001, 32'hC0000000, w);
    push(32'h7F800000, 32'h00000000, w);
    drain("drain_t3b");

    // Capacity: 5 accepted back-to-back, 6th refused
    out_ready = 1'b0;
    wsum = 0;
    for (int i = 0; i < 5; i++) begin
      push(32'h41000000 + (32'(i) << 16) + 32'(i), 32'h3FC00000 + (32'(i) << 8), w);
      wsum += w;
    end
    check_int("five_no_wait", wsum, 0);
    in_a = 32'h42000000; in_b = 32'h40400000; in_valid = 1'b1;
    @(negedge clk);
    check32("sixth_refused", 32'(in_ready), 0);

    // Hold in OUT with out_ready low: everything stable, no pop
    for (int n = 0; n < 40 && !out_valid; n++) begin @(posedge clk); #1; end
    check32("held_out_valid", 32'(out_valid), 1);
    s_res = out_result; s_exc = out_exception; s_a = div_a; s_b = div_b;
    stable = 1'b1; nopop = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_result !== s_res || out_exception !== s_exc || div_a !== s_a || div_b !== s_b)
        stable = 1'b0;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) nopop = 1'b0;
    end
    check32("hold_stable", 32'(stable), 1);
    check32("hold_no_pop", 32'(nopop), 1);

    out_ready = 1'b1;
    begin
      logic acc;
      acc = 1'b0;
      for (int n = 0; n < 100 && !acc; n++) begin
        @(negedge clk);
        if (in_ready) acc = 1'b1;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (acc) sb.push_back(model(32'h42000000, 32'h40400000));
      check_int("sixth_accepted", 32'(acc), 1);
    end
    drain("drain_t4");

    // Reset during WAIT with three entries queued
    for (int i = 0; i < 4; i++)
      push(32'h40800000 + (32'(i) << 12), 32'h3F900000 + 32'(i), w);
    rst = 1'b1;
    #1;
    check32("midrst_out_valid", 32'(out_valid), 0);
    check32("midrst_in_ready", 32'(in_ready), 1);
    check32("midrst_busy", 32'(busy), 0);
    check32("midrst_div_a", div_a, 32'h0);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    stale = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || busy) stale = 1'b1;
    end
    check32("no_stale", 32'(stale), 0);
    @(posedge clk); #1;
    push(32'h41200000, 32'h40A00000, w);
    latency("lat_after_rst", 1 + SETTLE);
    drain("drain_t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_div_issue.md
Name: fp_div_issue

Overview:
Sequential front-end and back-end controller for the combinational IEEE-754 single-precision divider core. Buffers operand pairs in a small FIFO and resolves special operands (NaN, Inf, zero) locally without using the core. All other pairs go to the core, which is given a fixed number of cycles to settle. The captured quotient is then returned through a valid/ready output port.

Parameters:
DEPTH, 4, operand FIFO entries; power of 2, minimum 2
SETTLE, 4, cycles the divider core is given to settle after operands change; minimum 1
PTR_W, $clog2(DEPTH), FIFO pointer width (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair offered
in_ready  output  1  FIFO can accept (= !full)
in_a  input  32  dividend, IEEE-754 single
in_b  input  32  divisor, IEEE-754 single
div_a  output  32  registered dividend to divider core
div_b  output  32  registered divisor to divider core
div_result  input  32  quotient from divider core
div_exception  input  1  exception flag from divider core
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_result  output  32  quotient
out_exception  output  1  exception flag
out_special  output  1  result produced by the bypass path, not the core
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, any state): FIFO pointers/count 0, state IDLE, div_a/div_b = 0, out_result = 0, out_exception = 0, out_special = 0, out_valid = 0. A reset mid-operation discards all queued and in-flight operations.
- Push: at an edge where in_valid && in_ready. in_ready = !full, computed from the current count only. A pop in the same cycle does not allow a push when full.
- FSM states: IDLE, WAIT, OUT.
- IDLE with FIFO non-empty: pop the head at the next edge and register it into div_a/div_b.
  - If the pair is special, load out_* directly and go to OUT.
  - Otherwise load cnt = SETTLE-1 and go to WAIT.
- WAIT: decrement cnt each cycle. At the edge where cnt == 0, capture div_result/div_exception into out_result/out_exception, set out_special = 0, and go to OUT.
- OUT: out_valid = 1 and out_* held stable. On out_ready go to IDLE, which can pop again at the following edge.
- Latency, counted in edges after the accepting edge E0, with an empty FIFO and out_ready = 1:
  - Normal path: out_valid high after edge E(1+SETTLE).
  - Special path: out_valid high after edge E1.
  - Issue interval: SETTLE+2 cycles normal, 2 cycles special.
- Total capacity: DEPTH queued plus 1 in flight.
- Special-case priority (first match wins; sign s = a[31]^b[31]; NaN = exp 0xFF with mant != 0; Inf = exp 0xFF with mant == 0; zero = exp 0 with mant == 0; denormals are treated as zero):
  1. a or b NaN -> 0x7FC00000, exception 1
  2. a Inf and b Inf -> 0x7FC00000, exception 1
  3. a zero and b zero -> 0x7FC00000, exception 1
  4. b zero -> {s, 0xFF, 23'h0}, exception 1
  5. a Inf -> {s, 0xFF, 23'h0}, exception 0
  6. b Inf or a zero -> {s, 31'h0}, exception 0
  7. otherwise not special; the core is used.
- div_a/div_b hold their last value outside a pop, which keeps the core output stable in OUT.

Decomposition:
- Shared package fp_pkg: constants QNAN = 32'h7FC00000, EXP_MAX = 8'hFF, and functions is_nan/is_inf/is_zero, reused by the add/sub and multiply front-ends.
- One sub-module fp_div_special, purely combinational: inputs a, b; outputs is_special, result, exception. It is instantiated at the FIFO head.
- The FIFO stays inline.

Test Plan:
1. SETTLE=4, push a=0x40C00000, b=0x40000000, core model returns 0x40400000 -> out_valid first high after E5, out_result=0x40400000, out_special=0, out_exception=0.
2. Push 0x3F800000/0x00000000 and 0xBF800000/0x00000000 -> 0x7F800000 then 0xFF800000, both exception=1, special=1, each valid after E1 of its pop.
3. Push 0/0, Inf/Inf (0x7F800000/0x7F800000), NaN 0x7FC00001/0x40000000 -> 0x7FC00000 ×3, exception=1; push 0x7F800000/0x40000000 -> 0x7F800000, exception=0.
4. DEPTH=4, out_ready=0, push 6 pairs back-to-back -> 5 accepted and in_ready=0 on the 6th. Release out_ready -> results emerge in push order and the 6th pair is accepted once a FIFO slot frees.
5. Hold out_ready=0 for 10 cycles in OUT -> out_result, out_exception, div_a and div_b all stable; no pop occurs.
6. Assert rst during WAIT with 3 entries queued -> immediately out_valid=0, in_ready=1, busy=0, div_a=0. After release, no stale results appear and a new push completes normally.
